// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host types, reply byte codes and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_LINEACK, S_WAIT_ACK, S_DONE
  } host_state_t;
  typedef enum logic [1:0] {
    RSP_OK = 2'b00, RSP_NAK = 2'b01, RSP_TIMEOUT = 2'b10, RSP_LINE_ERR = 2'b11
  } rsp_code_t;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_host_ctrl_if.sv
// ps2_host_ctrl_if: command/response, receive-decoder and PS/2 line signals of the host controller
interface ps2_host_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_inhibit;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  modport master (
    output cmd_valid, cmd_data, rx_valid, rx_data, ps2_clock, ps2_data,
    input  cmd_ready, rsp_valid, rsp_code, rx_inhibit, ps2_clock_oe, ps2_data_oe
  );
  modport slave (
    input  cmd_valid, cmd_data, rx_valid, rx_data, ps2_clock, ps2_data,
    output cmd_ready, rsp_valid, rsp_code, rx_inhibit, ps2_clock_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 3-flop synchroniser for raw PS/2 lines with rise/fall strobes
module ps2_line_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] i_line,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);
  logic [W-1:0] r_s0, r_s1, r_s2;
  always_ff @(posedge clk_i) begin
    r_s0 <= !rst_i ? '1 : i_line;
    r_s1 <= !rst_i ? '1 : r_s0;
    r_s2 <= !rst_i ? '1 : r_s1;
  end
  assign o_level = r_s1;
  assign o_rise  = ~r_s2 & r_s1;
  assign o_fall  = r_s2 & ~r_s1;
endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host-to-device command sender with line-ack check, reply wait and resend
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int BIT_TIMEOUT    = 750000,
  parameter int ACK_TIMEOUT    = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input logic            clk_i,
  input logic            rst_i,
  ps2_host_ctrl_if.slave bus
);
  localparam int TMAX = BIT_TIMEOUT > ACK_TIMEOUT ? BIT_TIMEOUT : ACK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] L_INH = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] L_BIT = TW'(BIT_TIMEOUT - 1);
  localparam logic [TW-1:0] L_ACK = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] L_RMAX = RW'(MAX_RETRY);
  host_state_t   r_state, w_next;
  rsp_code_t     r_rsp_code, w_code;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit, w_bit_n;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_byte;
  logic          r_cmd_ready, r_rsp_valid, r_rx_inhibit, r_clock_oe, r_data_oe;
  logic [1:0]    w_level, w_rise, w_fall;
  logic [8:0]    w_frame;
  logic          w_accept, w_edge, w_restart, w_unused;
  ps2_line_sync #(.W(2)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_line ({bus.ps2_data, bus.ps2_clock}),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );
  assign w_unused  = ^{w_rise, w_fall[1], w_level[0]};
  assign w_frame   = {odd_parity(r_byte), r_byte};
  assign w_accept  = r_state == S_IDLE && bus.cmd_valid;
  assign w_edge    = w_fall[0] && r_state inside {S_REQ, S_DATA, S_LINEACK};
  assign w_restart = w_next != r_state || w_edge;
  always_comb begin
    w_next  = r_state;
    w_code  = r_rsp_code;
    w_bit_n = r_bit;
    case (r_state)
      S_IDLE: begin
        w_next = w_accept ? S_INHIBIT : S_IDLE;
        w_code = w_accept ? RSP_OK : r_rsp_code;
      end
      S_INHIBIT: w_next = r_timer == L_INH ? S_REQ : S_INHIBIT;
      S_REQ, S_DATA, S_LINEACK: begin
        // a falling edge always beats a timeout landing in the same cycle
        if (w_edge) begin
          w_next  = r_state == S_REQ ? S_DATA :
                    r_state == S_LINEACK ? (w_level[1] ? S_DONE : S_WAIT_ACK) :
                    r_bit == 4'd8 ? S_LINEACK : S_DATA;
          w_bit_n = r_state == S_REQ ? 4'd0 : r_bit + 4'd1;
          w_code  = r_state == S_LINEACK && w_level[1] ? RSP_LINE_ERR : r_rsp_code;
        end else if (r_timer >= L_BIT) begin
          w_next = S_DONE;
          w_code = RSP_TIMEOUT;
        end
      end
      S_WAIT_ACK: begin
        if (bus.rx_valid && bus.rx_data == PS2_ACK) begin
          w_next = S_DONE;
          w_code = RSP_OK;
        end else if (bus.rx_valid && bus.rx_data == PS2_RESEND) begin
          w_next = r_retry < L_RMAX ? S_INHIBIT : S_DONE;
          w_code = r_retry < L_RMAX ? r_rsp_code : RSP_NAK;
        end else if (r_timer >= L_ACK) begin
          w_next = S_DONE;
          w_code = RSP_TIMEOUT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_rsp_code   <= RSP_OK;
      r_timer      <= '0;
      r_bit        <= '0;
      r_retry      <= '0;
      r_byte       <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rx_inhibit <= 1'b0;
      r_clock_oe   <= 1'b0;
      r_data_oe    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rsp_code   <= w_code;
      r_timer      <= w_restart ? '0 : r_timer + TW'(~&r_timer);
      r_bit        <= w_bit_n;
      r_retry      <= w_accept ? '0 :
                      r_state == S_WAIT_ACK && w_next == S_INHIBIT ? r_retry + RW'(1) : r_retry;
      r_byte       <= w_accept ? bus.cmd_data : r_byte;
      r_cmd_ready  <= w_next == S_IDLE;
      r_rsp_valid  <= w_next == S_DONE;
      r_rx_inhibit <= w_next inside {S_INHIBIT, S_REQ, S_DATA, S_LINEACK};
      r_clock_oe   <= w_next == S_INHIBIT;
      r_data_oe    <= w_next == S_REQ || (w_next == S_DATA && !w_frame[w_bit_n]);
    end
  end
  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_code     = r_rsp_code;
  assign bus.rx_inhibit   = r_rx_inhibit;
  assign bus.ps2_clock_oe = r_clock_oe;
  assign bus.ps2_data_oe  = r_data_oe;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: device BFM plus command table and response scoreboard for ps2_host_ctrl
module tb_ps2_host_ctrl;
  import ps2_pkg::*;
  localparam int H = 40;
  typedef struct {
    logic [7:0] cmd;
    int         n_fe;
    bit         line_err;
    bit         no_clk;
    bit         junk;
    bit         no_reply;
    int         frames;
    logic [1:0] code;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  vec_t v[7];
  ps2_host_ctrl_if bus ();
  ps2_host_ctrl #(
    .INHIBIT_CYCLES(100),
    .BIT_TIMEOUT   (2000),
    .ACK_TIMEOUT   (4000),
    .MAX_RETRY     (3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  assign bus.ps2_clock = dev_clk & ~bus.ps2_clock_oe;
  assign bus.ps2_data  = dev_data & ~bus.ps2_data_oe;
  always @(negedge clk) if (rst_n && bus.rsp_valid) obs_q.push_back(bus.rsp_code);
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic send_cmd(input logic [7:0] c);
    int k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_req();
    int k = 0;
    int len = 0;
    bit inh_ok = 1'b1;
    while (!bus.ps2_clock_oe && k < 300) begin
      @(negedge clk);
      k++;
    end
    while (bus.ps2_clock_oe && len < 1000) begin
      inh_ok &= bus.rx_inhibit;
      len++;
      @(negedge clk);
    end
    check("inhibit_len", len, 100);
    check("req_oe", int'({bus.ps2_clock_oe, bus.ps2_data_oe}), 1);
    check("inhibit_rx_inhibit", int'(inh_ok & bus.rx_inhibit), 1);
  endtask
  task automatic pulse(output logic b);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    b = bus.ps2_data;
    repeat (H) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] c, input bit ack);
    logic [9:0] got;
    logic [9:0] want;
    logic b;
    want = {1'b1, ~^c, c};
    repeat (10) @(negedge clk);
    check("start_bit", int'(bus.ps2_data), 0);
    for (int i = 0; i < 10; i++) begin
      pulse(b);
      got[i] = b;
    end
    check("frame_bits", int'(got), int'(want));
    dev_data = ~ack;
    repeat (5) @(negedge clk);
    pulse(b);
    dev_data = 1'b1;
  endtask
  task automatic reply(input logic [7:0] b);
    repeat (20) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    int k = 0;
    while (obs_q.size() == 0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (obs_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_wait: got no response in %0d clk, expected code %0d", k, exp_q[0]);
      exp_q.delete();
    end else check("rsp_code", int'(obs_q.pop_front()), int'(exp_q.pop_front()));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    logic b;
    v[0] = '{8'hED, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1, RSP_OK};
    v[1] = '{8'hF3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 4, RSP_OK};
    v[2] = '{8'hFF, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4, RSP_NAK};
    v[3] = '{8'hEE, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1, RSP_LINE_ERR};
    v[4] = '{8'hF2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1, RSP_TIMEOUT};
    v[5] = '{8'h60, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1, RSP_OK};
    v[6] = '{8'h55, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, RSP_TIMEOUT};
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_code", int'(bus.rsp_code), 0);
    check("rst_clock_oe", int'(bus.ps2_clock_oe), 0);
    check("rst_data_oe", int'(bus.ps2_data_oe), 0);
    check("rst_rx_inhibit", int'(bus.rx_inhibit), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = PS2_ACK;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_rx_ignored", obs_q.size(), 0);
    for (int t = 0; t < 7; t++) begin
      send_cmd(v[t].cmd);
      exp_q.push_back(v[t].code);
      for (int f = 0; f < v[t].frames; f++) begin
        wait_req();
        if (v[t].no_clk) begin
          k = 0;
          while (!bus.rsp_valid && k < 3000) begin
            @(negedge clk);
            k++;
          end
          check("req_timeout_clk", k, 2000);
          check("timeout_oe", int'({bus.ps2_clock_oe, bus.ps2_data_oe}), 0);
        end else begin
          frame(v[t].cmd, !v[t].line_err);
          if (!v[t].line_err) begin
            check("wait_ack_rx_inhibit", int'(bus.rx_inhibit), 0);
            if (v[t].junk) reply(8'hAA);
            if (!v[t].no_reply) reply(f < v[t].n_fe ? PS2_RESEND : PS2_ACK);
          end
        end
      end
      wait_rsp();
      repeat (5) @(negedge clk);
      check("code_held", int'(bus.rsp_code), int'(v[t].code));
      check("ready_after", int'(bus.cmd_ready), 1);
      check("no_extra_rsp", obs_q.size(), 0);
    end
    send_cmd(8'hA5);
    wait_req();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) pulse(b);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_oe", int'({bus.ps2_clock_oe, bus.ps2_data_oe}), 0);
    check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    check("midrst_rx_inhibit", int'(bus.rx_inhibit), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_cmd_ready", int'(bus.cmd_ready), 1);
    check("postrst_no_rsp", obs_q.size(), 0);
    send_cmd(8'hF4);
    exp_q.push_back(RSP_OK);
    wait_req();
    frame(8'hF4, 1'b1);
    reply(PS2_ACK);
    wait_rsp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
